mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single unified memory port between the instruction-fetch requester and the data requester, which is the memory-access stage. It holds at most one transaction outstanding, locks the winning requester until the memory accepts, and routes the response back to the owner. Data has fixed priority, and a saturating counter guarantees that fetch is not starved. The block sits between the pipeline stages and the memory model or BRAM wrapper.

## Interface
- STARVE_LIMIT, default 4: number of consecutive data grants while fetch is waiting, after which fetch wins; legal range is 1..15.
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- f_req_valid  in  1  fetch request
- f_req_ready  out  1  fetch request accepted this cycle
- f_req_addr  in  32  fetch byte address, read-only, full word
- f_resp_valid  out  1  fetch read data valid (one-cycle pulse)
- f_resp_data  out  32  fetch read data
- d_req_valid  in  1  data request
- d_req_ready  out  1  data request accepted this cycle
- d_req_addr  in  32  data byte address
- d_req_we  in  1  write enable
- d_req_byte_enable  in  4  byte lanes, already shifted by the stage
- d_req_wdata  in  32  write data, already lane-aligned
- d_resp_valid  out  1  data response or write acknowledge (one-cycle pulse)
- d_resp_data  out  32  raw memory word; the stage does extraction and sign extension
- mem_valid  out  1  request to memory
- mem_ready  in  1  memory accepts request
- mem_address  out  32
- mem_we  out  1
- mem_byte_enable  out  4  fetch drives 4'b1111
- mem_write  out  32  fetch drives 0
- mem_rvalid  in  1  memory response (reads and writes), in order
- mem_out  in  32  memory read word

## Operation
- FSM states:
  - ARB_IDLE: no owner.
  - ARB_REQ: owner locked, mem_valid held until mem_ready.
  - ARB_WAIT: accepted, awaiting mem_rvalid.
- Winner in ARB_IDLE:
  - Data wins if d_req_valid and NOT (f_req_valid and starve_cnt == STARVE_LIMIT).
  - Otherwise fetch wins if f_req_valid.
  - Otherwise there is no request.
- ARB_IDLE with a winner:
  - The mem_* outputs are muxed combinationally from the winner, with mem_valid=1.
  - If mem_ready: the winner's *_req_ready=1 and the next state is ARB_WAIT.
  - Otherwise the next state is ARB_REQ.
  - The owner is registered in both cases.
- ARB_REQ: mem_* are driven from the locked owner only, regardless of the other requester. On mem_ready, the owner's *_req_ready=1 and the next state is ARB_WAIT.
- ARB_WAIT:
  - mem_valid=0 and both *_req_ready=0.
  - On mem_rvalid, the owner's *_resp_valid=1 and *_resp_data=mem_out in the same cycle, combinationally, and the next state is ARB_IDLE.
- Only the owner's *_req_ready or *_resp_valid may ever be 1. The non-owner's resp_data is 0.
- Requesters hold valid and all request fields stable until ready. The arbiter does not check this.
- starve_cnt (4 bits):
  - Increments, saturating at STARVE_LIMIT, on each data acceptance while f_req_valid=1.
  - Clears on fetch acceptance, or whenever f_req_valid=0.
  - Holds otherwise.
- mem_rvalid in ARB_IDLE or ARB_REQ is spurious and is ignored with no response pulse.

## Timing
- Reset (rst_n=0 at a clk edge): state ARB_IDLE, owner cleared, starve_cnt=0. All outputs are 0 while reset is asserted.
- Reset mid-transaction: the outstanding response is discarded. A later mem_rvalid lands in ARB_IDLE and is ignored.
- Accept latency: 0 cycles when mem_ready is high in the request cycle, otherwise the cycle mem_ready rises.
- Response latency: the cycle mem_rvalid rises. There is no added register stage.
- The earliest possible next accept is the cycle after a response. Back-to-back throughput is one transaction per 2 cycles when memory has 1-cycle latency.
- Simultaneous f_req_valid and d_req_valid in ARB_IDLE: data wins unless starve_cnt==STARVE_LIMIT.
- A new request arriving in ARB_REQ or ARB_WAIT waits. It does not preempt.

## Structure
- Add to the cpu_types package:
  - typedef enum mem_owner_t {OWNER_FETCH, OWNER_DATA}
  - typedef enum arb_state_t {ARB_IDLE, ARB_REQ, ARB_WAIT}
- Single module with no sub-module. The request mux, FSM and counter are all local.

## Test plan
- Lone fetch, addr 0x100, mem_ready=1, mem_rvalid one cycle later with mem_out=0xDEADBEEF -> f_req_ready at cycle 0, f_resp_valid at cycle 1 with 0xDEADBEEF, and d_resp_valid stays 0.
- Data write, addr 0x203, be 4'b1000, wdata 0xAB000000, with mem_ready low for 3 cycles -> mem_* stable across all 3 cycles, d_req_ready only in the cycle mem_ready=1, then d_resp_valid pulses on mem_rvalid.
- f_req_valid and d_req_valid held continuously, STARVE_LIMIT=4 -> grant order is D,D,D,D,F,D,D,D,D,F, and starve_cnt returns to 0 after each F.
- Fetch locked in ARB_REQ, then d_req_valid rises before mem_ready -> the fetch is still the one accepted, and data is accepted in the following ARB_IDLE.
- rst_n=0 during ARB_WAIT, then mem_rvalid=1 after release -> no resp pulse, and a new request is accepted normally.
- mem_rvalid=1 in ARB_IDLE with no requests -> no response pulse and state unchanged.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory-port arbiter: owner encoding and FSM state codes.
package mem_port_arbiter_pkg;

  typedef enum logic {OWNER_FETCH = 1'b0, OWNER_DATA = 1'b1} mem_owner_t;

  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ARB_IDLE = 2'd0;
  localparam arb_state_t ARB_REQ  = 2'd1;
  localparam arb_state_t ARB_WAIT = 2'd2;

  localparam logic [3:0] FETCH_BYTE_ENABLE = 4'b1111;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data and memory-side handshake signals of the arbiter.
interface mem_port_arbiter_if;
  logic        f_req_valid;
  logic        f_req_ready;
  logic [31:0] f_req_addr;
  logic        f_resp_valid;
  logic [31:0] f_resp_data;

  logic        d_req_valid;
  logic        d_req_ready;
  logic [31:0] d_req_addr;
  logic        d_req_we;
  logic [3:0]  d_req_byte_enable;
  logic [31:0] d_req_wdata;
  logic        d_resp_valid;
  logic [31:0] d_resp_data;

  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_address;
  logic        mem_we;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_write;
  logic        mem_rvalid;
  logic [31:0] mem_out;

  // Arbiter side.
  modport slave (
    input  f_req_valid, f_req_addr,
    input  d_req_valid, d_req_addr, d_req_we, d_req_byte_enable, d_req_wdata,
    input  mem_ready, mem_rvalid, mem_out,
    output f_req_ready, f_resp_valid, f_resp_data,
    output d_req_ready, d_resp_valid, d_resp_data,
    output mem_valid, mem_address, mem_we, mem_byte_enable, mem_write
  );

  // Requesters plus memory, seen from outside the arbiter.
  modport master (
    output f_req_valid, f_req_addr,
    output d_req_valid, d_req_addr, d_req_we, d_req_byte_enable, d_req_wdata,
    output mem_ready, mem_rvalid, mem_out,
    input  f_req_ready, f_resp_valid, f_resp_data,
    input  d_req_ready, d_resp_valid, d_resp_data,
    input  mem_valid, mem_address, mem_we, mem_byte_enable, mem_write
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data onto one memory port, one transaction outstanding,
// data-priority with a saturating starvation counter protecting fetch.
//
// state    | meaning
// ARB_IDLE | no owner, pick a winner this cycle
// ARB_REQ  | owner locked, mem_valid held until mem_ready
// ARB_WAIT | accepted, awaiting mem_rvalid
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_port_arbiter_if.slave     bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_t  state_q, state_d;
  mem_owner_t  owner_q, owner_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;

  mem_owner_t  sel_owner;
  logic        win_data;
  logic        any_req;
  logic        drive;
  logic        accept;
  logic        resp;

  always_comb begin
    win_data  = bus.d_req_valid && !(bus.f_req_valid && (starve_cnt_q == LIMIT));
    any_req   = bus.d_req_valid || bus.f_req_valid;
    sel_owner = owner_q;
    if (state_q == ARB_IDLE) begin
      sel_owner = win_data ? OWNER_DATA : OWNER_FETCH;
    end
    drive  = ((state_q == ARB_IDLE) && any_req) || (state_q == ARB_REQ);
    accept = drive && bus.mem_ready;
    resp   = (state_q == ARB_WAIT) && bus.mem_rvalid;
  end

  always_comb begin
    bus.mem_valid       = 1'b0;
    bus.mem_address     = 32'd0;
    bus.mem_we          = 1'b0;
    bus.mem_byte_enable = 4'd0;
    bus.mem_write       = 32'd0;
    bus.f_req_ready     = 1'b0;
    bus.d_req_ready     = 1'b0;
    bus.f_resp_valid    = 1'b0;
    bus.f_resp_data     = 32'd0;
    bus.d_resp_valid    = 1'b0;
    bus.d_resp_data     = 32'd0;

    if (drive) begin
      bus.mem_valid = 1'b1;
      if (sel_owner == OWNER_DATA) begin
        bus.mem_address     = bus.d_req_addr;
        bus.mem_we          = bus.d_req_we;
        bus.mem_byte_enable = bus.d_req_byte_enable;
        bus.mem_write       = bus.d_req_wdata;
      end else begin
        bus.mem_address     = bus.f_req_addr;
        bus.mem_byte_enable = FETCH_BYTE_ENABLE;
      end
    end

    bus.f_req_ready = accept && (sel_owner == OWNER_FETCH);
    bus.d_req_ready = accept && (sel_owner == OWNER_DATA);

    if (resp) begin
      if (owner_q == OWNER_DATA) begin
        bus.d_resp_valid = 1'b1;
        bus.d_resp_data  = bus.mem_out;
      end else begin
        bus.f_resp_valid = 1'b1;
        bus.f_resp_data  = bus.mem_out;
      end
    end

    // Everything is forced quiet while reset is held.
    if (!rst_n) begin
      bus.mem_valid       = 1'b0;
      bus.mem_address     = 32'd0;
      bus.mem_we          = 1'b0;
      bus.mem_byte_enable = 4'd0;
      bus.mem_write       = 32'd0;
      bus.f_req_ready     = 1'b0;
      bus.d_req_ready     = 1'b0;
      bus.f_resp_valid    = 1'b0;
      bus.f_resp_data     = 32'd0;
      bus.d_resp_valid    = 1'b0;
      bus.d_resp_data     = 32'd0;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          owner_d = sel_owner;
          state_d = bus.mem_ready ? ARB_WAIT : ARB_REQ;
        end
      end
      ARB_REQ:  if (bus.mem_ready)  state_d = ARB_WAIT;
      ARB_WAIT: if (bus.mem_rvalid) state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.f_req_valid || (accept && (sel_owner == OWNER_FETCH))) begin
      starve_cnt_d = 4'd0;
    end else if (accept && (sel_owner == OWNER_DATA) && (starve_cnt_q < LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      owner_q      <= OWNER_FETCH;
      starve_cnt_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with STARVE_LIMIT=4.
module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic exp_f [10];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    exp_f   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    rst_n                 = 1'b0;
    bus.f_req_valid       = 1'b1;
    bus.f_req_addr        = 32'h0000_0010;
    bus.d_req_valid       = 1'b1;
    bus.d_req_addr        = 32'h0000_0020;
    bus.d_req_we          = 1'b1;
    bus.d_req_byte_enable = 4'hF;
    bus.d_req_wdata       = 32'h1111_1111;
    bus.mem_ready         = 1'b1;
    bus.mem_rvalid        = 1'b1;
    bus.mem_out           = 32'hFFFF_FFFF;
    step(); step();
    settle();
    chk("rst_mem_valid",   32'(bus.mem_valid), 32'd0);
    chk("rst_f_req_ready", 32'(bus.f_req_ready), 32'd0);
    chk("rst_d_req_ready", 32'(bus.d_req_ready), 32'd0);
    chk("rst_d_resp_valid", 32'(bus.d_resp_valid), 32'd0);
    chk("rst_mem_address", bus.mem_address, 32'd0);

    bus.f_req_valid = 1'b0;
    bus.d_req_valid = 1'b0;
    bus.d_req_we    = 1'b0;
    bus.mem_ready   = 1'b0;
    bus.mem_rvalid  = 1'b0;
    bus.mem_out     = 32'd0;
    step();
    rst_n = 1'b1;

    // Lone fetch, accepted immediately.
    step();
    bus.f_req_valid = 1'b1;
    bus.f_req_addr  = 32'h0000_0100;
    bus.mem_ready   = 1'b1;
    settle();
    chk("f1_mem_valid", 32'(bus.mem_valid), 32'd1);
    chk("f1_mem_addr", bus.mem_address, 32'h0000_0100);
    chk("f1_mem_be", 32'(bus.mem_byte_enable), 32'hF);
    chk("f1_mem_write", bus.mem_write, 32'd0);
    chk("f1_mem_we", 32'(bus.mem_we), 32'd0);
    chk("f1_f_req_ready", 32'(bus.f_req_ready), 32'd1);
    chk("f1_d_req_ready", 32'(bus.d_req_ready), 32'd0);
    step();
    bus.f_req_valid = 1'b0;
    bus.mem_ready   = 1'b0;
    bus.mem_rvalid  = 1'b1;
    bus.mem_out     = 32'hDEAD_BEEF;
    settle();
    chk("f1_resp_valid", 32'(bus.f_resp_valid), 32'd1);
    chk("f1_resp_data", bus.f_resp_data, 32'hDEAD_BEEF);
    chk("f1_d_resp_valid", 32'(bus.d_resp_valid), 32'd0);
    chk("f1_d_resp_data", bus.d_resp_data, 32'd0);
    chk("f1_wait_mem_valid", 32'(bus.mem_valid), 32'd0);
    step();
    bus.mem_rvalid = 1'b0;

    // Data write stalled 3 cycles by memory.
    bus.d_req_valid       = 1'b1;
    bus.d_req_addr        = 32'h0000_0203;
    bus.d_req_we          = 1'b1;
    bus.d_req_byte_enable = 4'b1000;
    bus.d_req_wdata       = 32'hAB00_0000;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("dw_stall_mem_valid", 32'(bus.mem_valid), 32'd1);
      chk("dw_stall_addr", bus.mem_address, 32'h0000_0203);
      chk("dw_stall_be", 32'(bus.mem_byte_enable), 32'h8);
      chk("dw_stall_wdata", bus.mem_write, 32'hAB00_0000);
      chk("dw_stall_we", 32'(bus.mem_we), 32'd1);
      chk("dw_stall_ready", 32'(bus.d_req_ready), 32'd0);
      step();
    end
    bus.mem_ready = 1'b1;
    settle();
    chk("dw_accept_ready", 32'(bus.d_req_ready), 32'd1);
    chk("dw_accept_addr", bus.mem_address, 32'h0000_0203);
    chk("dw_accept_f_ready", 32'(bus.f_req_ready), 32'd0);
    step();
    bus.d_req_valid = 1'b0;
    bus.d_req_we    = 1'b0;
    bus.mem_ready   = 1'b0;
    bus.mem_rvalid  = 1'b1;
    bus.mem_out     = 32'h1234_5678;
    settle();
    chk("dw_resp_valid", 32'(bus.d_resp_valid), 32'd1);
    chk("dw_resp_data", bus.d_resp_data, 32'h1234_5678);
    chk("dw_f_resp_valid", 32'(bus.f_resp_valid), 32'd0);
    step();
    bus.mem_rvalid = 1'b0;

    // Both requesting continuously: D,D,D,D,F,D,D,D,D,F.
    bus.f_req_valid       = 1'b1;
    bus.f_req_addr        = 32'h0000_0400;
    bus.d_req_valid       = 1'b1;
    bus.d_req_addr        = 32'h0000_0500;
    bus.d_req_byte_enable = 4'hF;
    for (int i = 0; i < 10; i++) begin
      bus.mem_ready  = 1'b1;
      bus.mem_rvalid = 1'b0;
      settle();
      chk($sformatf("starve_f_ready_%0d", i), 32'(bus.f_req_ready), 32'(exp_f[i]));
      chk($sformatf("starve_d_ready_%0d", i), 32'(bus.d_req_ready), 32'(!exp_f[i]));
      chk($sformatf("starve_addr_%0d", i), bus.mem_address,
          exp_f[i] ? 32'h0000_0400 : 32'h0000_0500);
      step();
      bus.mem_ready  = 1'b0;
      bus.mem_rvalid = 1'b1;
      bus.mem_out    = 32'h0000_1000 + 32'(i);
      settle();
      chk($sformatf("starve_f_resp_%0d", i), 32'(bus.f_resp_valid), 32'(exp_f[i]));
      chk($sformatf("starve_d_resp_%0d", i), 32'(bus.d_resp_valid), 32'(!exp_f[i]));
      step();
    end
    bus.f_req_valid = 1'b0;
    bus.d_req_valid = 1'b0;
    bus.mem_rvalid  = 1'b0;

    // Fetch locked in ARB_REQ is not preempted by a later data request.
    step();
    bus.f_req_valid = 1'b1;
    bus.f_req_addr  = 32'h0000_0600;
    settle();
    chk("lock_req_addr", bus.mem_address, 32'h0000_0600);
    chk("lock_req_f_ready", 32'(bus.f_req_ready), 32'd0);
    step();
    bus.d_req_valid = 1'b1;
    bus.d_req_addr  = 32'h0000_0700;
    settle();
    chk("lock_held_addr", bus.mem_address, 32'h0000_0600);
    chk("lock_held_be", 32'(bus.mem_byte_enable), 32'hF);
    chk("lock_held_d_ready", 32'(bus.d_req_ready), 32'd0);
    step();
    bus.mem_ready = 1'b1;
    settle();
    chk("lock_acc_f_ready", 32'(bus.f_req_ready), 32'd1);
    chk("lock_acc_d_ready", 32'(bus.d_req_ready), 32'd0);
    chk("lock_acc_addr", bus.mem_address, 32'h0000_0600);
    step();
    bus.f_req_valid = 1'b0;
    bus.mem_ready   = 1'b0;
    bus.mem_rvalid  = 1'b1;
    bus.mem_out     = 32'hCAFE_0001;
    settle();
    chk("lock_f_resp", 32'(bus.f_resp_valid), 32'd1);
    chk("lock_f_resp_data", bus.f_resp_data, 32'hCAFE_0001);
    chk("lock_d_resp", 32'(bus.d_resp_valid), 32'd0);
    step();
    bus.mem_rvalid = 1'b0;
    bus.mem_ready  = 1'b1;
    settle();
    chk("lock_next_d_ready", 32'(bus.d_req_ready), 32'd1);
    chk("lock_next_addr", bus.mem_address, 32'h0000_0700);
    step();
    bus.d_req_valid = 1'b0;
    bus.mem_ready   = 1'b0;
    bus.mem_rvalid  = 1'b1;
    bus.mem_out     = 32'hCAFE_0002;
    settle();
    chk("lock_next_d_resp", 32'(bus.d_resp_valid), 32'd1);
    chk("lock_next_d_data", bus.d_resp_data, 32'hCAFE_0002);
    step();
    bus.mem_rvalid = 1'b0;

    // Reset during ARB_WAIT discards the outstanding response.
    bus.f_req_valid = 1'b1;
    bus.f_req_addr  = 32'h0000_0800;
    bus.mem_ready   = 1'b1;
    settle();
    chk("rw_f_ready", 32'(bus.f_req_ready), 32'd1);
    step();
    bus.f_req_valid = 1'b0;
    bus.mem_ready   = 1'b0;
    bus.mem_rvalid  = 1'b1;
    bus.mem_out     = 32'h0000_0055;
    rst_n           = 1'b0;
    settle();
    chk("rw_rst_f_resp", 32'(bus.f_resp_valid), 32'd0);
    chk("rw_rst_f_data", bus.f_resp_data, 32'd0);
    step();
    rst_n = 1'b1;
    settle();
    chk("rw_late_f_resp", 32'(bus.f_resp_valid), 32'd0);
    chk("rw_late_d_resp", 32'(bus.d_resp_valid), 32'd0);
    step();
    bus.mem_rvalid        = 1'b0;
    bus.d_req_valid       = 1'b1;
    bus.d_req_addr        = 32'h0000_0900;
    bus.d_req_we          = 1'b1;
    bus.d_req_wdata       = 32'h0000_00AA;
    bus.mem_ready         = 1'b1;
    settle();
    chk("rw_new_d_ready", 32'(bus.d_req_ready), 32'd1);
    chk("rw_new_addr", bus.mem_address, 32'h0000_0900);
    step();
    bus.d_req_valid = 1'b0;
    bus.d_req_we    = 1'b0;
    bus.mem_ready   = 1'b0;
    bus.mem_rvalid  = 1'b1;
    bus.mem_out     = 32'd0;
    settle();
    chk("rw_new_d_resp", 32'(bus.d_resp_valid), 32'd1);
    step();

    // Spurious mem_rvalid in ARB_IDLE.
    bus.mem_rvalid = 1'b1;
    bus.mem_out    = 32'h7777_7777;
    settle();
    chk("sp_f_resp", 32'(bus.f_resp_valid), 32'd0);
    chk("sp_d_resp", 32'(bus.d_resp_valid), 32'd0);
    chk("sp_mem_valid", 32'(bus.mem_valid), 32'd0);
    step();
    bus.mem_rvalid  = 1'b0;
    bus.f_req_valid = 1'b1;
    bus.f_req_addr  = 32'h0000_0A00;
    bus.mem_ready   = 1'b1;
    settle();
    chk("sp_idle_f_ready", 32'(bus.f_req_ready), 32'd1);
    step();
    bus.f_req_valid = 1'b0;
    bus.mem_ready   = 1'b0;
    bus.mem_rvalid  = 1'b1;
    bus.mem_out     = 32'h0BAD_F00D;
    settle();
    chk("sp_after_f_resp", 32'(bus.f_resp_valid), 32'd1);
    chk("sp_after_f_data", bus.f_resp_data, 32'h0BAD_F00D);
    step();
    bus.mem_rvalid = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
